uart_tx_serializer: RTL

// - UART transmit stage; sits directly downstream of the baud rate generator.
// - Consumes the generator's square-wave tick and its error flag.
// - Accepts one byte per valid/ready handshake and serialises it LSB-first:

---
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit stage paced by the baud generator's tick square wave.
// Frames one handshaked word LSB-first: start bit, data bits, optional parity, stop bits.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 baud_err,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_abort
);

   localparam int TW = $clog2(OVERSAMPLE * 2);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e                 state_q, state_d;
   logic                   tick_q;
   logic [TW-1:0]          tickCnt_q, tickCnt_d;
   logic [BW-1:0]          bitCnt_q, bitCnt_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   parity_q, parity_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic                   abort_q, abort_d;
   logic                   tickRise;
   logic [TW-1:0]          lastCnt;
   logic                   bitEnd;

   // The stop period can span several bit periods, so it has its own terminal count.
   assign tickRise = baud_tick & ~tick_q;
   assign lastCnt  = (state_q == STOP) ? STOP_LAST : BIT_LAST;
   assign bitEnd   = tickRise && (tickCnt_q == lastCnt);

   assign tx_ready = (state_q == IDLE) & ~baud_err;
   assign tx       = tx_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = done_q;
   assign tx_abort = abort_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tick_q    <= 1'b0;
         tickCnt_q <= '0;
         bitCnt_q  <= '0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= baud_tick;
         tickCnt_q <= tickCnt_d;
         bitCnt_q  <= bitCnt_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   // Next-state logic; tx is derived from the next state so the line is registered.
   always_comb begin
      state_d   = state_q;
      tickCnt_d = tickCnt_q;
      bitCnt_d  = bitCnt_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      tx_d      = 1'b1;

      if ((state_q != IDLE) && tickRise)
         tickCnt_d = bitEnd ? '0 : tickCnt_q + TW'(1);

      unique case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               shreg_d   = tx_data;
               parity_d  = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
               tickCnt_d = '0;
               bitCnt_d  = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bitEnd) begin
               bitCnt_d = '0;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (bitEnd) begin
               shreg_d  = shreg_q >> 1;
               bitCnt_d = bitCnt_q + BW'(1);
               if (bitCnt_q == DATA_LAST)
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bitEnd)
               state_d = STOP;
         end
         STOP: begin
            if (bitEnd) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A failing baud generator kills the frame, even on its final stop tick.
      if ((state_q != IDLE) && baud_err) begin
         state_d   = IDLE;
         tickCnt_d = '0;
         bitCnt_d  = '0;
         done_d    = 1'b0;
         abort_d   = 1'b1;
      end

      unique case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = parity_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

endmodule
